pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit.
- Resolves the hazards that forwarding cannot cover: load-use, ID-stage branch operand dependence, and taken-branch fetch flush.
- Sequences the shared multi-cycle multiplier through a start/done handshake, freezing the front end while it runs.
- Keeps a saturating stall-cycle counter and a sticky multiplier-timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use and ID-branch stalls,
// taken-branch flush, and multi-cycle multiplier start/done sequencing with timeout.
module pipe_hazard_ctrl #(
  parameter int MUL_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_usesRt,
  input  logic             ID_isBranch,
  input  logic             ID_branchTaken,
  input  logic             ID_isMul,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_regWrite,
  input  logic             EX_memRead,
  input  logic [4:0]       MEM_Rd,
  input  logic             MEM_memRead,
  input  logic             mul_done,
  output logic             pcWrite,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             mul_start,
  output logic             mul_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(MUL_TIMEOUT - 1);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  typedef struct packed {
    logic hold;
    logic flush;
    logic start;
  } ctrl_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          lu, br, err_set;
  ctrl_t         ctl;

  // Register 0 is hardwired, so a match on it is never a dependence.
  always_comb begin
    lu = EX_memRead && (EX_Rd != 5'd0) &&
         ((EX_Rd == ID_Rs) || (ID_usesRt && (EX_Rd == ID_Rt)));
    br = ID_isBranch &&
         ((EX_regWrite && (EX_Rd != 5'd0) && ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt))) ||
          (MEM_memRead && (MEM_Rd != 5'd0) && ((MEM_Rd == ID_Rs) || (MEM_Rd == ID_Rt))));
  end

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    tcnt_nxt  = tcnt;
    err_set   = 1'b0;
    unique case (state)
      RUN: begin
        if (lu || br) begin
          ctl.hold = 1'b1;
        end else if (ID_isMul) begin
          ctl.hold  = 1'b1;
          ctl.start = 1'b1;
          state_nxt = MUL_WAIT;
          tcnt_nxt  = '0;
        end else if (ID_isBranch && ID_branchTaken) begin
          ctl.flush = 1'b1;
        end
      end
      MUL_WAIT: begin
        ctl.hold = 1'b1;
        tcnt_nxt = tcnt + 1'b1;
        // done beats timeout when both land in the same cycle
        if (mul_done) begin
          ctl.hold  = 1'b0;
          state_nxt = RUN;
        end else if (tcnt == TLAST) begin
          ctl.hold  = 1'b0;
          err_set   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are forced to their release values while reset is asserted.
  always_comb begin
    pcWrite      = !(ctl.hold && rst_n);
    IF_ID_write  = !(ctl.hold && rst_n);
    ID_EX_bubble = ctl.hold && rst_n;
    IF_ID_flush  = ctl.flush && rst_n;
    mul_start    = ctl.start && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      tcnt      <= '0;
      mul_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (err_set) mul_err <= 1'b1;
      if (!pcWrite && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// expected responses from a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 8;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
  logic          ID_usesRt, ID_isBranch, ID_branchTaken, ID_isMul;
  logic          EX_regWrite, EX_memRead, MEM_memRead, mul_done;
  logic          pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, mul_start, mul_err;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MUL_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_usesRt(ID_usesRt), .ID_isBranch(ID_isBranch),
    .ID_branchTaken(ID_branchTaken), .ID_isMul(ID_isMul),
    .EX_Rd(EX_Rd), .EX_regWrite(EX_regWrite), .EX_memRead(EX_memRead),
    .MEM_Rd(MEM_Rd), .MEM_memRead(MEM_memRead), .mul_done(mul_done),
    .pcWrite(pcWrite), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .mul_start(mul_start), .mul_err(mul_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs, rt, ex_rd, mem_rd;
    logic uses_rt, is_br, taken, is_mul, ex_rw, ex_mr, mem_mr, done, rst_n;
  } stim_t;

  typedef struct packed {
    logic pc, ifw, flush, bub, start, err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0, nbad = 0, nchk = 0;

  // behavioural model state
  bit busy = 0, err_m = 0;
  int waited = 0, stalls = 0;

  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit stall, flush, start, haz;
    @(posedge clk); #1;
    ID_Rs = s.rs; ID_Rt = s.rt; EX_Rd = s.ex_rd; MEM_Rd = s.mem_rd;
    ID_usesRt = s.uses_rt; ID_isBranch = s.is_br; ID_branchTaken = s.taken;
    ID_isMul = s.is_mul; EX_regWrite = s.ex_rw; EX_memRead = s.ex_mr;
    MEM_memRead = s.mem_mr; mul_done = s.done; rst_n = s.rst_n;
    stall = 0; flush = 0; start = 0;
    e.err = err_m; e.cnt = CW'(stalls);
    if (!s.rst_n) begin
      busy = 0; waited = 0; err_m = 0; stalls = 0;
      e.err = 0; e.cnt = 0;
    end else begin
      if (busy) begin
        if (s.done) busy = 0;
        else if (waited == TMO - 1) begin busy = 0; err_m = 1; end
        else stall = 1;
        waited++;
      end else begin
        haz = (s.ex_mr && (dep(s.ex_rd, s.rs) || (s.uses_rt && dep(s.ex_rd, s.rt)))) ||
              (s.is_br && ((s.ex_rw && (dep(s.ex_rd, s.rs) || dep(s.ex_rd, s.rt))) ||
                           (s.mem_mr && (dep(s.mem_rd, s.rs) || dep(s.mem_rd, s.rt)))));
        if (haz) stall = 1;
        else if (s.is_mul) begin stall = 1; start = 1; busy = 1; waited = 0; end
        else if (s.is_br && s.taken) flush = 1;
      end
      if (stall && stalls < SAT) stalls++;
    end
    e.pc = !stall; e.ifw = !stall; e.bub = stall; e.flush = flush; e.start = start;
    sb.push_back(e);
    nvec++;
  endtask

  // monitor: outputs are combinational, so sample mid-cycle
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        a = {pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, mul_start, mul_err, stall_cnt};
        nchk++;
        if (a !== e) begin
          nbad++;
          $display("FAIL vec%0d: got pc=%b ifw=%b fl=%b bub=%b st=%b err=%b cnt=%0d, want pc=%b ifw=%b fl=%b bub=%b st=%b err=%b cnt=%0d",
                   nchk, a.pc, a.ifw, a.flush, a.bub, a.start, a.err, a.cnt,
                   e.pc, e.ifw, e.flush, e.bub, e.start, e.err, e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    {ID_Rs, ID_Rt, EX_Rd, MEM_Rd} = '0;
    {ID_usesRt, ID_isBranch, ID_branchTaken, ID_isMul} = '0;
    {EX_regWrite, EX_memRead, MEM_memRead, mul_done} = '0;
    s = idle(); s.rst_n = 0;
    repeat (2) apply(s);

    // load-use on r8, then the same pattern on r0
    s = idle(); s.ex_mr = 1; s.ex_rd = 8; s.rs = 8; apply(s);
    apply(idle());
    s = idle(); s.ex_mr = 1; s.ex_rd = 0; s.rs = 0; apply(s);

    // branch operand hazard with taken ignored, then taken-branch flush
    s = idle(); s.is_br = 1; s.rt = 5; s.uses_rt = 1; s.ex_rw = 1; s.ex_rd = 5; s.taken = 1;
    apply(s);
    s = idle(); s.is_br = 1; s.rt = 5; s.uses_rt = 1; s.taken = 1; apply(s);

    // multiply with done on the fifth cycle after start
    s = idle(); s.is_mul = 1; apply(s);
    repeat (4) apply(idle());
    s = idle(); s.done = 1; apply(s);
    apply(idle());

    // timeout, then a normal multiply with the error latched
    s = idle(); s.is_mul = 1; apply(s);
    repeat (TMO + 1) apply(idle());
    s = idle(); s.is_mul = 1; apply(s);
    apply(idle());
    s = idle(); s.done = 1; apply(s);

    // fresh reset, then done on the last timeout cycle
    s = idle(); s.rst_n = 0; apply(s);
    s = idle(); s.is_mul = 1; apply(s);
    repeat (TMO - 1) apply(idle());
    s = idle(); s.done = 1; apply(s);
    repeat (2) apply(idle());

    // reset two cycles into a multiply, late done afterwards
    s = idle(); s.is_mul = 1; apply(s);
    repeat (2) apply(idle());
    s = idle(); s.rst_n = 0; repeat (2) apply(s);
    s = idle(); s.done = 1; apply(s);
    repeat (3) apply(idle());

    // counter saturation
    s = idle(); s.ex_mr = 1; s.ex_rd = 3; s.rs = 3;
    repeat (20) apply(s);
    repeat (2) apply(idle());

    // random traffic on a small register set so dependences are frequent
    for (int i = 0; i < 2000; i++) begin
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.ex_rd   = 5'($urandom_range(0, 3));
      s.mem_rd  = 5'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom);
      s.is_br   = ($urandom % 3) == 0;
      s.taken   = 1'($urandom);
      s.is_mul  = ($urandom % 5) == 0;
      s.ex_rw   = 1'($urandom);
      s.ex_mr   = ($urandom % 3) == 0;
      s.mem_mr  = ($urandom % 3) == 0;
      s.done    = ($urandom % 6) == 0;
      s.rst_n   = ($urandom % 60) != 0;
      apply(s);
    end

    @(negedge clk); #1;
    if (sb.size() != 0 || nchk != nvec) begin
      nbad++;
      $display("FAIL drain: checked %0d of %0d vectors, %0d left queued", nchk, nvec, sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checked %0d of %0d", nchk, nvec);
    $fatal(1, "watchdog");
  end

endmodule
